// File: rtl/cpu_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// cpu_oci_dct_packer
//   Write side of the OCI data-capture-trace path. Packs CODE_W-bit trace
//   codes into a CODE_W*SLOTS-bit dct_buffer word with a code count, and hands
//   each frame to the DCT consumer over a valid/ready handshake. On
//   test_ending the partial frame is closed and drained before
//   test_has_ended rises.
//
// Ports
//   clk            sole clock, rising edge
//   reset_n        asynchronous active-low reset
//   code_valid     trace code offered
//   code           trace code
//   code_ready     packer accepts a code this cycle
//   flush          single-cycle request to emit the partial frame
//   test_ending    single-cycle end-of-test request
//   frame_valid    dct_buffer/dct_count hold a frame
//   frame_ready    consumer takes the frame
//   dct_buffer     packed codes, oldest code in the highest used bits
//   dct_count      number of valid codes in dct_buffer (1..SLOTS)
//   test_has_ended sticky, every code delivered after test_ending
//   overflow       sticky, a code was dropped (DCT_DROP_ON_STALL_EN only)
//
// Build option
//   DCT_DROP_ON_STALL_EN : code_ready stays high in RUN; a code arriving while
//   the accumulator is full and the output register is blocked is dropped and
//   overflow is set. Undefined: back-pressure via code_ready, overflow = 0.
// ---------------------------------------------------------------------------
module cpu_oci_dct_packer #(
  parameter int unsigned CODE_W = 2,
  parameter int unsigned SLOTS  = 15
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           code_valid,
  input  logic [CODE_W-1:0]              code,
  output logic                           code_ready,
  input  logic                           flush,
  input  logic                           test_ending,
  output logic                           frame_valid,
  input  logic                           frame_ready,
  output logic [CODE_W*SLOTS-1:0]        dct_buffer,
  output logic [$clog2(SLOTS+1)-1:0]     dct_count,
  output logic                           test_has_ended,
  output logic                           overflow
);

  localparam int unsigned BUF_W = CODE_W * SLOTS;
  localparam int unsigned CNT_W = $clog2(SLOTS + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ENDED = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Accumulator and held-close flag
  logic [BUF_W-1:0] acc, acc_nxt, acc_app;
  logic [CNT_W-1:0] acc_cnt, cnt_nxt, cnt_app;
  logic             close_pend, pend_nxt;

  // Output holding register
  logic [BUF_W-1:0] out_buf, ld_buf;
  logic [CNT_W-1:0] out_cnt, ld_cnt;
  logic             out_valid, load;

  logic accept;
  logic out_free;
  logic close_now;

`ifdef DCT_DROP_ON_STALL_EN
  logic lost;
  logic ovf_q;
`endif

  assign accept   = code_valid && code_ready;
  assign out_free = !out_valid || frame_ready;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_RUN;
    else          state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN:   if (test_ending) state_nxt = ST_DRAIN;
      ST_DRAIN: if (acc_cnt == '0 && !close_pend && !out_valid)
                  state_nxt = ST_ENDED;
      ST_ENDED: state_nxt = ST_ENDED;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    code_ready     = 1'b0;
    test_has_ended = 1'b0;
    if (state == ST_RUN) begin
`ifdef DCT_DROP_ON_STALL_EN
      code_ready = 1'b1;
`else
      code_ready = !(close_pend && out_valid && !frame_ready);
`endif
    end
    if (state == ST_ENDED) test_has_ended = 1'b1;
  end

  // -------------------------------------------------------------------------
  // Accumulator / close datapath
  // -------------------------------------------------------------------------
  always_comb begin
    acc_app   = {acc[BUF_W-CODE_W-1:0], code};
    cnt_app   = acc_cnt + CNT_W'(1);
    acc_nxt   = acc;
    cnt_nxt   = acc_cnt;
    pend_nxt  = close_pend;
    load      = 1'b0;
    ld_buf    = acc;
    ld_cnt    = acc_cnt;
    close_now = 1'b0;
`ifdef DCT_DROP_ON_STALL_EN
    lost      = 1'b0;
`endif
    if (close_pend) begin
      // A held close ships the accumulator as it stands; a code accepted in
      // the same cycle starts the next frame instead of over-filling this one.
      // Any flush arriving now merges into the held close.
      if (out_free) begin
        load     = 1'b1;
        pend_nxt = 1'b0;
        acc_nxt  = accept ? BUF_W'(code) : '0;
        cnt_nxt  = accept ? CNT_W'(1) : '0;
      end else if (accept) begin
        if (acc_cnt == FULL_CNT) begin
`ifdef DCT_DROP_ON_STALL_EN
          lost = 1'b1;
`endif
        end else begin
          acc_nxt = acc_app;
          cnt_nxt = cnt_app;
        end
      end
    end else begin
      if (accept) begin
        acc_nxt = acc_app;
        cnt_nxt = cnt_app;
      end
      close_now = (cnt_nxt != '0) &&
                  ((cnt_nxt == FULL_CNT) ||
                   (state == ST_RUN && (flush || test_ending)) ||
                   (state == ST_DRAIN));
      if (close_now) begin
        if (out_free) begin
          load    = 1'b1;
          ld_buf  = acc_nxt;
          ld_cnt  = cnt_nxt;
          acc_nxt = '0;
          cnt_nxt = '0;
        end else begin
          pend_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc        <= '0;
      acc_cnt    <= '0;
      close_pend <= 1'b0;
      out_buf    <= '0;
      out_cnt    <= '0;
      out_valid  <= 1'b0;
    end else begin
      acc        <= acc_nxt;
      acc_cnt    <= cnt_nxt;
      close_pend <= pend_nxt;
      if (load) begin
        out_buf   <= ld_buf;
        out_cnt   <= ld_cnt;
        out_valid <= 1'b1;
      end else if (out_valid && frame_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef DCT_DROP_ON_STALL_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  ovf_q <= 1'b0;
    else if (lost) ovf_q <= 1'b1;
  end
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign frame_valid = out_valid;
  assign dct_buffer  = out_buf;
  assign dct_count   = out_cnt;

endmodule

// File: tb/tb_cpu_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// tb_cpu_oci_dct_packer
//   Directed bench for cpu_oci_dct_packer: full frame, partial flush,
//   back-pressure, simultaneous events, end-of-test drain and reset.
//   Inputs change 1 ns after a rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_cpu_oci_dct_packer;

  logic        clk;
  logic        reset_n;
  logic        code_valid;
  logic [1:0]  code;
  logic        code_ready;
  logic        flush;
  logic        test_ending;
  logic        frame_valid;
  logic        frame_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_has_ended;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  cpu_oci_dct_packer #(.CODE_W(2), .SLOTS(15)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .code_valid     (code_valid),
    .code           (code),
    .code_ready     (code_ready),
    .flush          (flush),
    .test_ending    (test_ending),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_has_ended (test_has_ended),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input logic v, input logic [3:0] c,
                           input logic [29:0] b);
    chk({tag, "_valid"}, 32'(frame_valid), 32'(v));
    chk({tag, "_count"}, 32'(dct_count), 32'(c));
    chk({tag, "_buf"},   32'(dct_buffer), 32'(b));
  endtask

  initial begin
    reset_n     = 1'b0;
    code_valid  = 1'b0;
    code        = '0;
    flush       = 1'b0;
    test_ending = 1'b0;
    frame_ready = 1'b0;
    tick();
    tick();
    chk_frame("reset", 1'b0, 4'd0, 30'h0);
    chk("reset_ended", 32'(test_has_ended), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("ready_after_reset", 32'(code_ready), 32'd1);

    // Full frame: 0,1,2,3,... 15 codes
    frame_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      code_valid = 1'b1;
      code       = 2'(i % 4);
      tick();
    end
    code_valid = 1'b0;
    chk_frame("full", 1'b1, 4'd15, 30'h06C6C6C6);
    tick();
    chk("full_taken", 32'(frame_valid), 32'd0);

    // Partial flush: 3,2,1 then flush; empty flush yields nothing
    code_valid = 1'b1; code = 2'd3; tick();
    code = 2'd2; tick();
    code = 2'd1; tick();
    code_valid = 1'b0;
    chk("partial_no_early_frame", 32'(frame_valid), 32'd0);
    flush = 1'b1; tick();
    flush = 1'b0;
    chk_frame("partial", 1'b1, 4'd3, 30'h39);
    tick();
    chk("partial_taken", 32'(frame_valid), 32'd0);
    flush = 1'b1; tick();
    flush = 1'b0;
    chk("empty_flush", 32'(frame_valid), 32'd0);

    // Back-pressure: 30 codes fill two frames, 31st stalls
    frame_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      code_valid = 1'b1;
      code       = (i < 15) ? 2'd3 : 2'd1;
      tick();
    end
    code = 2'd2;
    #1;
    chk("bp_stall_ready", 32'(code_ready), 32'd0);
    tick();
    chk_frame("bp_first_held", 1'b1, 4'd15, 30'h3FFFFFFF);
    chk("bp_still_stalled", 32'(code_ready), 32'd0);
    frame_ready = 1'b1;
    #1;
    chk("bp_ready_on_release", 32'(code_ready), 32'd1);
    tick();
    code_valid = 1'b0;
    chk_frame("bp_second_no_bubble", 1'b1, 4'd15, 30'h15555555);
    tick();
    chk("bp_second_taken", 32'(frame_valid), 32'd0);
    flush = 1'b1; tick();
    flush = 1'b0;
    chk_frame("bp_31st_code", 1'b1, 4'd1, 30'h2);
    tick();
    chk("bp_done", 32'(frame_valid), 32'd0);
`ifndef DCT_DROP_ON_STALL_EN
    chk("bp_no_overflow", 32'(overflow), 32'd0);
`endif

    // Simultaneous: accept+flush, then close+transfer
    code_valid = 1'b1; code = 2'd1; tick();
    code = 2'd2; tick();
    code = 2'd3; flush = 1'b1; tick();
    chk_frame("accept_flush", 1'b1, 4'd3, 30'h1B);
    code = 2'd0; tick();
    code_valid = 1'b0; flush = 1'b0;
    chk_frame("close_transfer", 1'b1, 4'd1, 30'h0);
    tick();
    chk("sim_taken", 32'(frame_valid), 32'd0);

    // End of test: 5 codes, test_ending, consumer delayed 4 cycles
    frame_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      code_valid = 1'b1;
      code       = 2'd2;
      tick();
    end
    code_valid = 1'b0;
    test_ending = 1'b1; tick();
    test_ending = 1'b0;
    chk_frame("eot_frame", 1'b1, 4'd5, 30'h2AA);
    code_valid = 1'b1;
    #1;
    chk("eot_ready_low", 32'(code_ready), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    code_valid = 1'b0;
    chk("eot_still_held", 32'(frame_valid), 32'd1);
    chk("eot_not_ended", 32'(test_has_ended), 32'd0);
    frame_ready = 1'b1; tick();
    chk("eot_taken", 32'(frame_valid), 32'd0);
    chk("eot_ended_not_yet", 32'(test_has_ended), 32'd0);
    tick();
    chk("eot_ended", 32'(test_has_ended), 32'd1);
    flush = 1'b1; test_ending = 1'b1; code_valid = 1'b1; tick();
    flush = 1'b0; test_ending = 1'b0; code_valid = 1'b0;
    tick();
    chk("ended_sticky", 32'(test_has_ended), 32'd1);
    chk("ended_no_frame", 32'(frame_valid), 32'd0);
    chk("ended_ready_low", 32'(code_ready), 32'd0);

    // Reset clears everything
    reset_n = 1'b0;
    #1;
    chk("rst2_ended", 32'(test_has_ended), 32'd0);
    chk_frame("rst2", 1'b0, 4'd0, 30'h0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst2_ready", 32'(code_ready), 32'd1);

`ifdef DCT_DROP_ON_STALL_EN
    // Drop on stall: 40 codes with consumer blocked, 10 dropped
    frame_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      code_valid = 1'b1;
      code       = 2'd1;
      tick();
    end
    code_valid = 1'b0;
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk_frame("drop_first", 1'b1, 4'd15, 30'h15555555);
    frame_ready = 1'b1; tick();
    chk_frame("drop_second", 1'b1, 4'd15, 30'h15555555);
    tick();
    chk("drop_done", 32'(frame_valid), 32'd0);
    flush = 1'b1; tick();
    flush = 1'b0;
    chk("drop_nothing_left", 32'(frame_valid), 32'd0);
    chk("drop_ovf_sticky", 32'(overflow), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
